// File: rtl/gpio_in_pkg.sv
// Shared constants and helpers for the GPIO input conditioning slice.
// Pure declarations: no latency or flow control of its own.
package gpio_in_pkg;

   localparam int DEBOUNCE_20MS_50MHZ = 1_000_000;
   localparam int DEFAULT_SYNC_STAGES = 2;

   // Width that can hold 0..debounce_cycles.
   function automatic int cnt_width(input int debounce_cycles);
      return $clog2(debounce_cycles + 1);
   endfunction

endpackage

// File: rtl/gpio_in_debounce_if.sv
// Board-input bundle: raw pins and event clears in, conditioned levels, pulses and flags out.
// Wires only: no latency, no backpressure.
interface gpio_in_debounce_if
   import gpio_in_pkg::*;
#(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] pins_in;
   logic [WIDTH-1:0] clr_events;
   logic [WIDTH-1:0] level_out;
   logic [WIDTH-1:0] rise_pulse;
   logic [WIDTH-1:0] fall_pulse;
   logic [WIDTH-1:0] event_sticky;

   modport master (
      output pins_in, clr_events,
      input  level_out, rise_pulse, fall_pulse, event_sticky
   );

   modport slave (
      input  pins_in, clr_events,
      output level_out, rise_pulse, fall_pulse, event_sticky
   );
endinterface

// File: rtl/gpio_debounce_chan.sv
// One channel: synchronizer, debounce counter, stable level, edge pulses, sticky flag.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges to acceptance, outputs registered; no backpressure.
module gpio_debounce_chan
   import gpio_in_pkg::*;
#(
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_pin,
   input  logic i_clr,
   output logic o_level,
   output logic o_rise,
   output logic o_fall,
   output logic o_sticky
);
   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt;
   logic                   r_stable;
   logic                   r_rise;
   logic                   r_fall;
   logic                   r_sticky;

   logic w_sync_q;
   logic w_mismatch;
   logic w_accept;

   assign w_sync_q   = r_sync[SYNC_STAGES-1];
   assign w_mismatch = (w_sync_q != r_stable);
   assign w_accept   = w_mismatch && (r_cnt == CNT_LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync   <= '0;
         r_cnt    <= '0;
         r_stable <= 1'b0;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
         r_sticky <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};

         // Any return to the stable level restarts the count.
         if (!w_mismatch) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_cnt    <= '0;
            r_stable <= w_sync_q;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end

         r_rise <= w_accept &&  w_sync_q;
         r_fall <= w_accept && !w_sync_q;

         // A new edge outranks a same-cycle clear.
         if (w_accept) begin
            r_sticky <= 1'b1;
         end else if (i_clr) begin
            r_sticky <= 1'b0;
         end
      end
   end

   assign o_level  = r_stable;
   assign o_rise   = r_rise;
   assign o_fall   = r_fall;
   assign o_sticky = r_sticky;

endmodule

// File: rtl/gpio_in_debounce.sv
// Debounces WIDTH asynchronous board inputs into the 50 MHz domain, one channel instance per bit.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges, all outputs registered; no backpressure.
module gpio_in_debounce
   import gpio_in_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ
) (
   input  logic                clk_50MHz,
   input  logic                arst,
   gpio_in_debounce_if.slave   bus
);
   logic [WIDTH-1:0] w_level;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_sticky;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      gpio_debounce_chan #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_chan (
         .i_clk    (clk_50MHz),
         .i_rst    (arst),
         .i_pin    (bus.pins_in[i]),
         .i_clr    (bus.clr_events[i]),
         .o_level  (w_level[i]),
         .o_rise   (w_rise[i]),
         .o_fall   (w_fall[i]),
         .o_sticky (w_sticky[i])
      );
   end

   assign bus.level_out    = w_level;
   assign bus.rise_pulse   = w_rise;
   assign bus.fall_pulse   = w_fall;
   assign bus.event_sticky = w_sticky;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Scoreboarded bench for gpio_in_debounce: directed scenarios then random pins, clears and resets.
// Reference model: a level is accepted once the last DEBOUNCE_CYCLES synchronized samples all differ from it.
module tb_gpio_in_debounce;
   localparam int W = 4;
   localparam int S = 2;
   localparam int D = 4;

   logic clk = 1'b0;
   logic arst;

   gpio_in_debounce_if #(.WIDTH(W)) bus();

   gpio_in_debounce #(
      .WIDTH           (W),
      .SYNC_STAGES     (S),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk_50MHz (clk),
      .arst      (arst),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Expected {level, rise, fall, sticky} for the cycle after each edge.
   logic [4*W-1:0] exp_q[$];

   // Model state: pin samples taken at each edge since reset (oldest first).
   logic [W-1:0] hist[$];
   logic [W-1:0] m_stable;
   logic [W-1:0] m_sticky;
   logic [W-1:0] m_acc;
   logic [W-1:0] m_rise;
   logic [W-1:0] m_fall;
   logic         m_all;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (arst) begin
         hist.delete();
         for (int k = 0; k < S + D; k++) hist.push_back('0);
         m_stable = '0;
         m_sticky = '0;
         exp_q.push_back('0);
      end else begin
         hist.push_back(bus.pins_in);
         void'(hist.pop_front());
         m_acc = '0;
         for (int i = 0; i < W; i++) begin
            m_all = 1'b1;
            // Value compared at this edge is the sample from S edges earlier.
            for (int k = 0; k < D; k++)
               if (hist[hist.size() - 1 - S - k][i] == m_stable[i]) m_all = 1'b0;
            m_acc[i] = m_all;
         end
         m_rise   = m_acc & ~m_stable;
         m_fall   = m_acc &  m_stable;
         m_stable = m_stable ^ m_acc;
         m_sticky = m_acc | (m_sticky & ~bus.clr_events);
         exp_q.push_back({m_stable, m_rise, m_fall, m_sticky});
      end
   end

   logic [4*W-1:0] got;
   logic [4*W-1:0] want;

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         got = {bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.event_sticky};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty cyc %0d got %h", cyc, got);
         end else begin
            want = exp_q.pop_front();
            if (arst) want = '0;
            if (got !== want) begin
               errors++;
               $display("FAIL outputs cyc %0d got lvl/rise/fall/sticky %h required %h",
                        cyc, got, want);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      arst           = 1'b1;
      bus.pins_in    = W'($urandom);
      bus.clr_events = '0;
      tick(3);
      bus.pins_in    = W'($urandom);
      tick(1);
      bus.pins_in    = '0;
      arst           = 1'b0;
      tick(8);

      // Step on channel 0
      bus.pins_in[0] = 1'b1;
      tick(10);

      // Short glitch on channel 1
      bus.pins_in[1] = 1'b1;
      tick(3);
      bus.pins_in[1] = 1'b0;
      tick(10);

      // Bounce on channel 2
      for (int k = 0; k < 6; k++) begin
         bus.pins_in[2] = ~bus.pins_in[2];
         tick(2);
      end
      bus.pins_in[2] = 1'b1;
      tick(12);

      // Clear coinciding with an accepted fall, then clear alone
      bus.pins_in[0] = 1'b0;
      tick(5);
      bus.clr_events[0] = 1'b1;
      tick(1);
      bus.clr_events[0] = 1'b0;
      tick(1);
      bus.clr_events[0] = 1'b1;
      tick(1);
      bus.clr_events[0] = 1'b0;
      tick(4);

      // Reset in the middle of a count on channel 3
      bus.pins_in[3] = 1'b1;
      tick(4);
      arst = 1'b1;
      tick(1);
      arst = 1'b0;
      tick(12);

      // Random phase
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < W; i++)
            if ($urandom_range(5) == 0) bus.pins_in[i] = ~bus.pins_in[i];
         bus.clr_events = ($urandom_range(3) == 0) ? W'($urandom) : '0;
         arst = ($urandom_range(99) == 0);
         tick(1);
      end
      arst = 1'b0;
      bus.clr_events = '0;
      tick(12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
